// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction adds the ten's complement and re-complements when a borrow remains.
module bcd_addsub_seq #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   result,
  output logic                  negative,
  output logic                  overflow,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, ADD, NEGATE, DONE
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] a_q;
  logic [4*DIGITS-1:0] b_q;
  logic [4*DIGITS-1:0] r_q;
  logic                op_q;
  logic                carry;
  logic [IW-1:0]       idx;

  logic                bad;
  logic [3:0]          lhs;
  logic [3:0]          rhs;
  logic [4:0]          sum;
  logic [4:0]          adj;
  logic                c_out;
  logic [4*DIGITS-1:0] r_next;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[4*i +: 4] > 4'd9) bad = 1'b1;
      if (b_q[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // ADD: a_i + (b_i or 9-b_i); NEGATE: 0 + (9-r_i). Both share the carry rule.
  always_comb begin
    lhs = 4'd0;
    rhs = 4'd9 - r_q[idx*4 +: 4];
    if (state == ADD) begin
      lhs = a_q[idx*4 +: 4];
      rhs = op_q ? (4'd9 - b_q[idx*4 +: 4]) : b_q[idx*4 +: 4];
    end
    sum   = {1'b0, lhs} + {1'b0, rhs} + {4'b0, carry};
    c_out = (sum > 5'd9);
    adj   = c_out ? (sum - 5'd10) : sum;
    r_next = r_q;
    r_next[idx*4 +: 4] = adj[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      op_q     <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bad) begin
            result   <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx   <= '0;
            carry <= op_q;
            r_q   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          r_q   <= r_next;
          carry <= c_out;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            if (op_q && !c_out) begin
              carry <= 1'b1;
              idx   <= '0;
              state <= NEGATE;
            end else begin
              result   <= r_next;
              negative <= 1'b0;
              overflow <= !op_q && c_out;
              invalid  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        NEGATE: begin
          r_q   <= r_next;
          carry <= c_out;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            result   <= r_next;
            negative <= 1'b1;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed-vector bench for bcd_addsub_seq (DIGITS=3).
// Checks latency, results, flags, start-while-busy and mid-op reset.
module tb_bcd_addsub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [11:0] a;
  logic [11:0] b;
  logic [11:0] result;
  logic        negative;
  logic        overflow;
  logic        invalid;
  logic        busy;
  logic        done;

  int n_chk;
  int n_pass;

  bcd_addsub_seq #(.DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .result(result), .negative(negative),
    .overflow(overflow), .invalid(invalid), .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic o,
                        input logic [11:0] av, input logic [11:0] bv,
                        input int ecyc, input logic [11:0] eres,
                        input logic eneg, input logic eovf,
                        input logic einv);
    int cyc;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 12'h999; b = 12'h999; op = ~o;
    cyc = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_cyc"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_res"}, 32'(result), 32'(eres));
    chk({tag, "_flags"}, 32'({negative, overflow, invalid}),
        32'({eneg, eovf, einv}));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int cyc;
    int dn;
    int dcyc;
    logic busy_ok;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'({result, negative, overflow, invalid, busy, done}), 32'd0);
    rst = 1'b0;

    run_op("add_ovf",  1'b0, 12'h456, 12'h789, 5, 12'h245, 1'b0, 1'b1, 1'b0);
    run_op("sub_pos",  1'b1, 12'h123, 12'h045, 5, 12'h078, 1'b0, 1'b0, 1'b0);
    run_op("sub_neg",  1'b1, 12'h045, 12'h123, 8, 12'h078, 1'b1, 1'b0, 1'b0);
    run_op("sub_eq",   1'b1, 12'h500, 12'h500, 5, 12'h000, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 12'h999, 12'h001, 5, 12'h000, 1'b0, 1'b1, 1'b0);
    run_op("inval",    1'b0, 12'h1A3, 12'h001, 2, 12'h000, 1'b0, 1'b0, 1'b1);
    run_op("post_inv", 1'b0, 12'h001, 12'h001, 5, 12'h002, 1'b0, 1'b0, 1'b0);

    // start held high through cycles 1..5, including the DONE cycle
    @(negedge clk);
    op = 1'b0; a = 12'h456; b = 12'h789; start = 1'b1;
    @(posedge clk); #1;
    a = 12'h001; b = 12'h001;
    cyc = 1; dn = 0; dcyc = 0; busy_ok = 1'b1;
    while (cyc <= 5) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin dn++; dcyc = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("ign_busy_drop", 32'(busy), 32'd0);
    repeat (8) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("ign_busy_held", 32'(busy_ok), 32'd1);
    chk("ign_one_done", 32'(dn), 32'd1);
    chk("ign_done_cyc", 32'(dcyc), 32'd5);
    chk("ign_res", 32'(result), 32'h245);

    // reset in cycle 3 of a negative subtraction
    @(negedge clk);
    op = 1'b1; a = 12'h045; b = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    repeat (2) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_outs", 32'({result, negative, overflow, invalid, busy, done}), 32'd0);
    rst = 1'b0;
    repeat (10) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", 32'(dn), 32'd0);
    run_op("post_rst", 1'b0, 12'h001, 12'h001, 5, 12'h002, 1'b0, 1'b0, 1'b0);

    // rst and start together: start dropped
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 1'b0; a = 12'h111; b = 12'h111;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start", 32'({busy, result}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_seq.md
# bcd_addsub_seq

Parametrised, digit-serial BCD adder/subtractor for unsigned packed-BCD operands of DIGITS decimal digits. It processes one digit per clock, least-significant first. Subtraction uses ten's-complement addition and re-complements on borrow, so results are always sign-magnitude. It sits behind the switch/keypad capture logic and in front of the seven-segment display drivers, with a start/done handshake to the controlling FSM.

## Interface
- DIGITS, 3: number of BCD digits per operand and result; legal range ≥1.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only while busy=0.
- op  input  1  operation select: 0 = a+b, 1 = a−b; captured with start.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]; captured with start.
- b  input  4*DIGITS  operand B, same format; captured with start.
- result  output  4*DIGITS  magnitude of the result, packed BCD.
- negative  output  1  result is negative (sub only); never set for a zero result.
- overflow  output  1  add produced a carry out of the top digit; result holds the low DIGITS digits.
- invalid  output  1  some captured digit of a or b was >9; result forced to 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; the result outputs update on the same edge.

## Operation
- States: IDLE, CHECK, ADD, NEGATE, DONE. The digit index counter is max(1,$clog2(DIGITS)) bits wide.
- IDLE:
  - If start=1, capture a, b and op, and go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (1 cycle):
  - If any digit of the captured a or b is >9, set the pending flags to invalid=1, result=0, negative=0, overflow=0, and go to DONE.
  - Otherwise: index=0, carry=op, go to ADD.
- ADD (DIGITS cycles), per digit i:
  - y = op ? 9−b_i : b_i.
  - s = a_i + y + carry, 5 bits, max 19.
  - If s>9: r_i = s−10, carry=1. Otherwise: r_i = s, carry=0.
  - Index increments each cycle.
- After the last digit in ADD:
  - op=0: overflow=carry, negative=0, go to DONE.
  - op=1, carry=1: a≥b, negative=0, go to DONE.
  - op=1, carry=0: a<b. Set negative=1, carry=1, index=0, go to NEGATE.
- NEGATE (DIGITS cycles): r_i ← digit-adjust of (9−r_i)+carry, with the same carry rule as ADD. Go to DONE after the last digit.
- DONE (1 cycle):
  - done=1.
  - result, negative, overflow and invalid are loaded from the working registers.
  - Go to IDLE.
- Output registers hold their values until the next DONE.
- overflow is always 0 for sub. invalid clears on the next valid operation.

## Timing
- Reset values: result=0, negative=0, overflow=0, invalid=0, busy=0, done=0, state=IDLE.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled.
- Phase schedule:
  - CHECK: cycle 1.
  - ADD: cycles 2..DIGITS+1.
  - NEGATE, when taken: cycles DIGITS+2..2·DIGITS+1.
- done asserts in:
  - cycle 2 for invalid operands;
  - cycle DIGITS+2 for add and for non-negative sub;
  - cycle 2·DIGITS+2 for negative sub.
- busy=1 from cycle 1 through the done cycle inclusive.
- start while busy=1, including the DONE cycle, is ignored and not queued. The earliest next accept is the cycle after done.
- Operands and op may change freely after cycle 0; only the captured copies are used.
- rst mid-operation: return to IDLE next edge with all outputs at reset values. No done pulse for the aborted operation.
- rst and start in the same cycle: rst wins and start is dropped.
- a=b on sub: result 0, negative=0, via the carry=1 path (no negative zero).
- DIGITS=1: same state sequence, with single-cycle ADD and NEGATE.

## Test plan
- DIGITS=3, op=0, a=456, b=789 → done in cycle 5, result=245, overflow=1, negative=0, invalid=0.
- op=1, a=123, b=045 → done in cycle 5, result=078, negative=0, overflow=0.
- op=1, a=045, b=123 → intermediate 922 with carry 0 → NEGATE → done in cycle 8, result=078, negative=1.
- op=1, a=500, b=500 → done in cycle 5, result=000, negative=0. Then op=0, a=999, b=001 → result=000, overflow=1.
- op=0, a=0x1A3, b=0x001 → done in cycle 2, invalid=1, result=000. A following valid 001+001 → result=002, invalid=0.
- Two checks in one run:
  - Pulse start again in cycles 1–5 of an operation → ignored, exactly one done, busy never drops early.
  - Assert rst in cycle 3 of a 045−123 operation → no done pulse, all outputs 0 next cycle. A new start is accepted the cycle after rst deasserts.
